// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control FSM
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_EXEC_R,
        S_EXEC_I, S_EXEC_B, S_EXEC_JAL, S_EXEC_JALR, S_EXEC_U, S_LINK, S_ALU_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
        ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_PASSB = 4'd10
    } alu_ctr_t;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0, CAUSE_OPCODE = 2'd1, CAUSE_TIMEOUT = 2'd2, CAUSE_BRANCH = 2'd3
    } cause_t;

    function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_LUI, OP_AUIPC:  return IMM_U;
            OP_JAL:            return IMM_J;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - control FSM <-> datapath/memory signal bundle
interface mc_ctrl_fsm_if #(
    parameter int DBG_W = 4
);
    logic [31:0]      instr;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic             mem_rdy;
    logic             run;
    logic             pc_write;
    logic             adr_src;
    logic             mem_req;
    logic             mem_we;
    logic             ir_write;
    logic [1:0]       result_src;
    logic [3:0]       alu_ctr;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       imm_src;
    logic             reg_w;
    logic             valid;
    logic             halt;
    logic [DBG_W-1:0] debug_port;

    modport master (
        input  instr, zero, lt, ltu, mem_rdy, run,
        output pc_write, adr_src, mem_req, mem_we, ir_write, result_src, alu_ctr,
               alu_src_a, alu_src_b, imm_src, reg_w, valid, halt, debug_port
    );

    modport slave (
        output instr, zero, lt, ltu, mem_rdy, run,
        input  pc_write, adr_src, mem_req, mem_we, ir_write, result_src, alu_ctr,
               alu_src_a, alu_src_b, imm_src, reg_w, valid, halt, debug_port
    );
endinterface

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// rtl/mc_ctrl_fsm_alu_dec.sv - funct decode to ALU op and branch-taken evaluation
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       op_b5,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic [3:0] alu_ctr,
    output logic       br_taken,
    output logic       br_illegal
);

    always_comb begin
        alu_ctr = ALU_ADD;
        case (funct3)
            3'b000: alu_ctr = (op_b5 && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctr = ALU_SLL;
            3'b010: alu_ctr = ALU_SLT;
            3'b011: alu_ctr = ALU_SLTU;
            3'b100: alu_ctr = ALU_XOR;
            3'b101: alu_ctr = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_ctr = ALU_OR;
            default: alu_ctr = ALU_AND;
        endcase
    end

    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            3'b000: br_taken = zero;
            3'b001: br_taken = !zero;
            3'b100: br_taken = lt;
            3'b101: br_taken = !lt;
            3'b110: br_taken = ltu;
            3'b111: br_taken = !ltu;
            default: br_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32I control FSM with memory timeout and trap
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit RESET_HALT  = 1'b0,
    parameter int DBG_W       = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    mc_ctrl_fsm_if.master bus
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state, state_nxt;
    cause_t           cause, cause_nxt;
    logic [CNT_W-1:0] wait_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] dec_alu;
    logic       br_taken, br_illegal;
    logic       mem_wait, timeout;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[6:0];
    assign funct3            = bus.instr[14:12];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    alu_dec u_alu_dec (
        .funct3    (funct3),
        .funct7_b5 (bus.instr[30]),
        .op_b5     (opcode[5]),
        .zero      (bus.zero),
        .lt        (bus.lt),
        .ltu       (bus.ltu),
        .alu_ctr   (dec_alu),
        .br_taken  (br_taken),
        .br_illegal(br_illegal)
    );

    assign mem_wait = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !bus.mem_rdy;
    assign timeout  = mem_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            cause    <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            cause <= cause_nxt;
            if (mem_wait && state_nxt == state)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    logic       pc_write_c, adr_src_c, mem_req_c, mem_we_c, ir_write_c, reg_w_c;
    logic [1:0] result_src_c, src_a_c, src_b_c;
    logic [3:0] alu_ctr_c;

    always_comb begin
        state_nxt    = state;
        cause_nxt    = cause;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        ir_write_c   = 1'b0;
        reg_w_c      = 1'b0;
        result_src_c = RES_ALUOUT;
        src_a_c      = SRC_A_PC;
        src_b_c      = SRC_B_RS2;
        alu_ctr_c    = ALU_ADD;

        case (state)
            S_IDLE: if (!RESET_HALT || bus.run) state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req_c    = 1'b1;
                src_b_c      = SRC_B_FOUR;
                result_src_c = RES_ALU;
                if (bus.mem_rdy) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_nxt  = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            // Branch/JAL target is precomputed here into aluOut.
            S_DECODE: begin
                src_a_c = SRC_A_OLDPC;
                src_b_c = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_EXEC_B;
                    OP_JAL:            state_nxt = S_EXEC_JAL;
                    OP_JALR:           state_nxt = S_EXEC_JALR;
                    OP_LUI, OP_AUIPC:  state_nxt = S_EXEC_U;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_OPCODE;
                    end
                endcase
            end
            S_MEM_ADR: begin
                src_a_c   = SRC_A_RS1;
                src_b_c   = SRC_B_IMM;
                state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                mem_we_c  = (state == S_MEM_WR);
                if (bus.mem_rdy) begin
                    state_nxt = (state == S_MEM_WR) ? S_FETCH : S_MEM_WB;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                result_src_c = RES_MEM;
                reg_w_c      = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                src_a_c   = SRC_A_RS1;
                src_b_c   = (state == S_EXEC_I) ? SRC_B_IMM : SRC_B_RS2;
                alu_ctr_c = dec_alu;
                state_nxt = S_ALU_WB;
            end
            S_EXEC_B: begin
                src_a_c    = SRC_A_RS1;
                alu_ctr_c  = ALU_SUB;
                pc_write_c = br_taken;
                if (br_illegal) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BRANCH;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC_JAL: begin
                pc_write_c = 1'b1;
                state_nxt  = S_LINK;
            end
            S_EXEC_JALR: begin
                src_a_c      = SRC_A_RS1;
                src_b_c      = SRC_B_IMM;
                result_src_c = RES_ALU;
                pc_write_c   = 1'b1;
                state_nxt    = S_LINK;
            end
            S_LINK: begin
                src_a_c   = SRC_A_OLDPC;
                src_b_c   = SRC_B_FOUR;
                state_nxt = S_ALU_WB;
            end
            S_EXEC_U: begin
                src_b_c = SRC_B_IMM;
                if (opcode == OP_LUI) begin
                    alu_ctr_c = ALU_PASSB;
                end else begin
                    src_a_c = SRC_A_OLDPC;
                end
                state_nxt = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_w_c   = 1'b1;
                state_nxt = S_FETCH;
            end
            default: begin
                if (bus.run) begin
                    state_nxt = S_FETCH;
                    cause_nxt = CAUSE_NONE;
                end
            end
        endcase
    end

    // Reset gates every output so an access interrupted by reset cannot commit.
    assign bus.pc_write   = !sys_rst && pc_write_c;
    assign bus.adr_src    = !sys_rst && adr_src_c;
    assign bus.mem_req    = !sys_rst && mem_req_c;
    assign bus.mem_we     = !sys_rst && mem_we_c;
    assign bus.ir_write   = !sys_rst && ir_write_c;
    assign bus.reg_w      = !sys_rst && reg_w_c;
    assign bus.valid      = !sys_rst && (state == S_FETCH);
    assign bus.halt       = !sys_rst && (state == S_TRAP);
    assign bus.result_src = sys_rst ? 2'b00 : result_src_c;
    assign bus.alu_ctr    = sys_rst ? 4'b0000 : alu_ctr_c;
    assign bus.alu_src_a  = sys_rst ? 2'b00 : src_a_c;
    assign bus.alu_src_b  = sys_rst ? 2'b00 : src_b_c;
    assign bus.imm_src    = sys_rst ? 3'b000 : imm_sel(opcode);
    assign bus.debug_port = sys_rst ? '0 : {{(DBG_W - 2){1'b0}}, cause};

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic sys_rst;
    int   checks = 0;
    int   failures = 0;

    mc_ctrl_fsm_if #(.DBG_W(4)) bus ();

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .RESET_HALT(1'b0), .DBG_W(4)) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_BLTU  = 32'h0020_E463;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_BAD   = 32'h0000_007F;
    localparam logic [31:0] I_BR010 = 32'h0020_A463;

    // {pc_write, adr_src, mem_req, mem_we, ir_write, result_src, alu_ctr, src_a, src_b, imm_src, reg_w, valid, halt}
    function automatic logic [31:0] ow(input logic pw, input logic as, input logic mr, input logic mw,
                                       input logic iw, input logic [1:0] rs, input logic [3:0] ac,
                                       input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] is,
                                       input logic rw, input logic v, input logic h);
        return {11'b0, pw, as, mr, mw, iw, rs, ac, sa, sb, is, rw, v, h};
    endfunction

    function automatic logic [31:0] obs_outs();
        return {11'b0, bus.pc_write, bus.adr_src, bus.mem_req, bus.mem_we, bus.ir_write, bus.result_src,
                bus.alu_ctr, bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.reg_w, bus.valid, bus.halt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] exp);
        #1;
        chk(tag, obs_outs(), exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst     = 1'b1;
        bus.instr   = I_ADDI;
        bus.zero    = 1'b0;
        bus.lt      = 1'b0;
        bus.ltu     = 1'b0;
        bus.mem_rdy = 1'b1;
        bus.run     = 1'b0;

        // reset forces all outputs low
        cyc();
        cyc();
        chk_outs("rst_outs", 32'h0);
        chk("rst_dbg", 32'(bus.debug_port), 32'h0);
        sys_rst = 1'b0;
        chk_outs("idle", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b000,0,0,0));

        // addi x1,x0,5
        cyc(); chk_outs("addi_fetch",  ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b000,0,1,0));
        cyc(); chk_outs("addi_decode", ow(0,0,0,0,0,2'b00,4'd0,2'b01,2'b01,3'b000,0,0,0));
        cyc(); chk_outs("addi_exec_i", ow(0,0,0,0,0,2'b00,4'd0,2'b10,2'b01,3'b000,0,0,0));
        cyc(); chk_outs("addi_alu_wb", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b000,1,0,0));

        // bltu taken, then not taken
        cyc(); bus.instr = I_BLTU; bus.ltu = 1'b1;
        chk_outs("bltu_fetch", ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b010,0,1,0));
        cyc(); chk_outs("bltu_decode", ow(0,0,0,0,0,2'b00,4'd0,2'b01,2'b01,3'b010,0,0,0));
        cyc(); chk_outs("bltu_taken",  ow(1,0,0,0,0,2'b00,4'd1,2'b10,2'b00,3'b010,0,0,0));
        cyc(); bus.ltu = 1'b0;
        chk_outs("bltu2_fetch", ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b010,0,1,0));
        cyc(); cyc();
        chk_outs("bltu_not_taken", ow(0,0,0,0,0,2'b00,4'd1,2'b10,2'b00,3'b010,0,0,0));

        // lw with three wait cycles in MEM_RD
        cyc(); bus.instr = I_LW;
        chk_outs("lw_fetch", ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b000,0,1,0));
        cyc();
        cyc(); bus.mem_rdy = 1'b0;
        chk_outs("lw_mem_adr", ow(0,0,0,0,0,2'b00,4'd0,2'b10,2'b01,3'b000,0,0,0));
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) bus.mem_rdy = 1'b1;
            chk_outs($sformatf("lw_mem_rd_%0d", i), ow(0,1,1,0,0,2'b00,4'd0,2'b00,2'b00,3'b000,0,0,0));
        end
        cyc(); chk_outs("lw_mem_wb", ow(0,0,0,0,0,2'b01,4'd0,2'b00,2'b00,3'b000,1,0,0));

        // fetch timeout after 16 wait cycles
        cyc(); bus.mem_rdy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_outs($sformatf("to_fetch_%0d", i), ow(0,0,1,0,0,2'b10,4'd0,2'b00,2'b10,3'b000,0,1,0));
            cyc();
        end
        chk_outs("to_trap", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b000,0,0,1));
        chk("to_cause", 32'(bus.debug_port), 32'd2);
        cyc(); chk_outs("to_trap_hold", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b000,0,0,1));
        bus.run = 1'b1; bus.mem_rdy = 1'b1;
        cyc(); bus.run = 1'b0;
        chk_outs("to_restart", ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b000,0,1,0));
        chk("to_cause_clr", 32'(bus.debug_port), 32'd0);

        // illegal opcode
        bus.instr = I_BAD;
        cyc(); cyc();
        chk_outs("bad_op_trap", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b000,0,0,1));
        chk("bad_op_cause", 32'(bus.debug_port), 32'd1);
        bus.run = 1'b1;
        cyc(); bus.run = 1'b0; bus.instr = I_BR010;
        chk_outs("br010_fetch", ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b010,0,1,0));

        // branch with reserved funct3
        cyc(); cyc();
        chk_outs("br010_exec", ow(0,0,0,0,0,2'b00,4'd1,2'b10,2'b00,3'b010,0,0,0));
        cyc();
        chk_outs("br010_trap", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b010,0,0,1));
        chk("br010_cause", 32'(bus.debug_port), 32'd3);
        bus.run = 1'b1;
        cyc(); bus.run = 1'b0; bus.instr = I_SW;

        // sw interrupted by reset during its wait
        cyc(); cyc(); bus.mem_rdy = 1'b0;
        chk_outs("sw_mem_adr", ow(0,0,0,0,0,2'b00,4'd0,2'b10,2'b01,3'b001,0,0,0));
        cyc(); chk_outs("sw_mem_wr", ow(0,1,1,1,0,2'b00,4'd0,2'b00,2'b00,3'b001,0,0,0));
        cyc(); sys_rst = 1'b1;
        chk_outs("sw_rst_outs", 32'h0);
        cyc(); sys_rst = 1'b0; bus.mem_rdy = 1'b1;
        chk_outs("sw_rst_idle", ow(0,0,0,0,0,2'b00,4'd0,2'b00,2'b00,3'b001,0,0,0));
        cyc(); chk_outs("sw_rst_fetch", ow(1,0,1,0,1,2'b10,4'd0,2'b00,2'b10,3'b001,0,1,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
